condlogic_mt: RTL and testbench

//  Pipelined, multi-thread ARM condition unit for the EX/MEM boundary. Keeps
//  one NZCV flag bank and one saved-flags bank per hardware thread. Evaluates
//  the EX-stage condition against the issuing thread's bank and gates PC, register
//  and memory writes. Registers the surviving write enables into MEM, with

---
 rtl/condlogic_mt.sv | 143 ++++++++++++++
 tb/tb_condlogic_mt.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/condlogic_mt.sv
// rtl/condlogic_mt.sv - multi-thread ARM condition unit with per-thread NZCV banks
// Gates PC/register/memory writes in EX and registers surviving enables into MEM.

module condlogic_mt_cond (
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);
  logic n, z, c, v;

  assign {n, z, c, v} = nzcv;

  always_comb begin
    pass = 1'b0;
    case (cond)
      4'h0: pass = z;
      4'h1: pass = ~z;
      4'h2: pass = c;
      4'h3: pass = ~c;
      4'h4: pass = n;
      4'h5: pass = ~n;
      4'h6: pass = v;
      4'h7: pass = ~v;
      4'h8: pass = c & ~z;
      4'h9: pass = ~c | z;
      4'hA: pass = (n == v);
      4'hB: pass = (n != v);
      4'hC: pass = ~z & (n == v);
      4'hD: pass = z | (n != v);
      4'hE: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule

module condlogic_mt #(
  parameter int NTHREAD = 2,
  parameter int TIDW    = (NTHREAD > 1) ? $clog2(NTHREAD) : 1,
  parameter int CNTW    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_e,
  input  logic                 stall_e,
  input  logic                 flush_e,
  input  logic [TIDW-1:0]      tid_e,
  input  logic [3:0]           cond_e,
  input  logic [3:0]           alu_flags_e,
  input  logic [1:0]           flag_w_e,
  input  logic                 branch_e,
  input  logic                 pcs_e,
  input  logic                 reg_w_e,
  input  logic                 mem_w_e,
  input  logic                 save_e,
  input  logic                 restore_e,
  output logic                 cond_ex_e,
  output logic                 pc_src_e,
  output logic                 reg_w_m,
  output logic                 mem_w_m,
  output logic                 valid_m,
  output logic [TIDW-1:0]      tid_m,
  output logic [4*NTHREAD-1:0] flags_o,
  output logic [CNTW-1:0]      squash_cnt
);
  logic [3:0] cur_flags;
  logic       pass;
  logic       fire;

  // Out-of-range thread ids select nothing, so the condition sees all-zero flags.
  always_comb begin
    cur_flags = 4'b0000;
    for (int t = 0; t < NTHREAD; t++) begin
      if (tid_e == TIDW'(t)) cur_flags = flags_o[4*t +: 4];
    end
  end

  condlogic_mt_cond u_cond (
    .cond (cond_e),
    .nzcv (cur_flags),
    .pass (pass)
  );

  assign cond_ex_e = valid_e & pass & ~flush_e;
  assign pc_src_e  = cond_ex_e & (branch_e | pcs_e);
  assign fire      = valid_e & ~stall_e & ~flush_e;

  for (genvar t = 0; t < NTHREAD; t++) begin : g_bank
    logic [3:0] bank_q;
    logic [3:0] saved_q;
    logic [3:0] bank_d;
    logic       hit;

    assign hit = fire & (tid_e == TIDW'(t));

    // Restore wins over a same-cycle flag write; save always captures the old bank.
    always_comb begin
      bank_d = bank_q;
      if (cond_ex_e & flag_w_e[1]) bank_d[3:2] = alu_flags_e[3:2];
      if (cond_ex_e & flag_w_e[0]) bank_d[1:0] = alu_flags_e[1:0];
      if (restore_e) bank_d = saved_q;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        bank_q  <= 4'b0000;
        saved_q <= 4'b0000;
      end else if (hit) begin
        bank_q <= bank_d;
        if (save_e) saved_q <= bank_q;
      end
    end

    assign flags_o[4*t +: 4] = bank_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_m <= 1'b0;
      reg_w_m <= 1'b0;
      mem_w_m <= 1'b0;
      tid_m   <= '0;
    end else begin
      if (flush_e) begin
        valid_m <= 1'b0;
        reg_w_m <= 1'b0;
        mem_w_m <= 1'b0;
      end else if (!stall_e) begin
        valid_m <= valid_e;
        reg_w_m <= reg_w_e & cond_ex_e;
        mem_w_m <= mem_w_e & cond_ex_e;
      end
      if (!stall_e) tid_m <= tid_e;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      squash_cnt <= '0;
    end else if (fire && !pass && !(&squash_cnt)) begin
      squash_cnt <= squash_cnt + CNTW'(1);
    end
  end
endmodule

// File: tb/tb_condlogic_mt.sv
// tb/tb_condlogic_mt.sv - randomized scoreboard bench for condlogic_mt
// Driver pushes model predictions per cycle; a monitor pops them after each edge.

module tb_condlogic_mt;
  localparam int NT = 3;
  localparam int TW = 2;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            valid_e, stall_e, flush_e;
  logic [TW-1:0]   tid_e;
  logic [3:0]      cond_e, alu_flags_e;
  logic [1:0]      flag_w_e;
  logic            branch_e, pcs_e, reg_w_e, mem_w_e, save_e, restore_e;
  logic            cond_ex_e, pc_src_e, reg_w_m, mem_w_m, valid_m;
  logic [TW-1:0]   tid_m;
  logic [4*NT-1:0] flags_o;
  logic [CW-1:0]   squash_cnt;

  always #5 clk = ~clk;

  condlogic_mt #(.NTHREAD(NT), .TIDW(TW), .CNTW(CW)) dut (
    .clk(clk), .reset(reset), .valid_e(valid_e), .stall_e(stall_e), .flush_e(flush_e),
    .tid_e(tid_e), .cond_e(cond_e), .alu_flags_e(alu_flags_e), .flag_w_e(flag_w_e),
    .branch_e(branch_e), .pcs_e(pcs_e), .reg_w_e(reg_w_e), .mem_w_e(mem_w_e),
    .save_e(save_e), .restore_e(restore_e), .cond_ex_e(cond_ex_e), .pc_src_e(pc_src_e),
    .reg_w_m(reg_w_m), .mem_w_m(mem_w_m), .valid_m(valid_m), .tid_m(tid_m),
    .flags_o(flags_o), .squash_cnt(squash_cnt)
  );

  typedef struct packed {
    logic       valid, stall, flush;
    logic [1:0] tid;
    logic [3:0] cond, alu;
    logic [1:0] fw;
    logic       branch, pcs, reg_w, mem_w, save, restore;
  } stim_t;

  typedef struct packed {
    logic            vm, rm, mm;
    logic [1:0]      tid;
    logic [4*NT-1:0] flags;
    logic [CW-1:0]   cnt;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  logic [3:0] mflags[NT];
  logic [3:0] msaved[NT];
  logic       mvm, mrm, mmm;
  logic [1:0] mtid;
  int         mcnt;
  int         nvec = 0;
  int         nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit arm_pass(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      0: return z;             1: return !z;
      2: return c;             3: return !c;
      4: return n;             5: return !n;
      6: return v;             7: return !v;
      8: return c && !z;       9: return !c || z;
      10: return n == v;       11: return n != v;
      12: return !z && n == v; 13: return z || n != v;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model_snapshot();
    exp_t e;
    e.vm = mvm; e.rm = mrm; e.mm = mmm; e.tid = mtid;
    for (int t = 0; t < NT; t++) e.flags[4*t +: 4] = mflags[t];
    e.cnt = CW'(mcnt);
    return e;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < NT; t++) begin mflags[t] = 4'h0; msaved[t] = 4'h0; end
    mvm = 0; mrm = 0; mmm = 0; mtid = 0; mcnt = 0;
  endtask

  task automatic compare_regs(input string tag, input exp_t e);
    chk({tag, " valid_m"}, 32'(valid_m), 32'(e.vm));
    chk({tag, " reg_w_m"}, 32'(reg_w_m), 32'(e.rm));
    chk({tag, " mem_w_m"}, 32'(mem_w_m), 32'(e.mm));
    chk({tag, " tid_m"}, 32'(tid_m), 32'(e.tid));
    chk({tag, " flags_o"}, 32'(flags_o), 32'(e.flags));
    chk({tag, " squash_cnt"}, 32'(squash_cnt), 32'(e.cnt));
  endtask

  task automatic drive(input stim_t s);
    valid_e = s.valid; stall_e = s.stall; flush_e = s.flush; tid_e = s.tid;
    cond_e = s.cond; alu_flags_e = s.alu; flag_w_e = s.fw; branch_e = s.branch;
    pcs_e = s.pcs; reg_w_e = s.reg_w; mem_w_e = s.mem_w; save_e = s.save;
    restore_e = s.restore;
  endtask

  // One EX cycle: check combinational outputs, advance the model, queue the MEM view.
  task automatic go(input stim_t s);
    logic [3:0] sel, old, olds, nf;
    bit p, cex, fire, inrange;
    @(negedge clk);
    drive(s);
    #1;
    inrange = int'(s.tid) < NT;
    sel = 4'h0;
    if (inrange) sel = mflags[s.tid];
    p = arm_pass(s.cond, sel);
    cex = s.valid && p && !s.flush;
    fire = s.valid && !s.stall && !s.flush;
    chk("cond_ex_e", 32'(cond_ex_e), 32'(cex));
    chk("pc_src_e", 32'(pc_src_e), 32'(cex && (s.branch || s.pcs)));
    if (fire && inrange) begin
      old = mflags[s.tid];
      olds = msaved[s.tid];
      nf = old;
      if (cex && s.fw[1]) nf[3:2] = s.alu[3:2];
      if (cex && s.fw[0]) nf[1:0] = s.alu[1:0];
      if (s.restore) nf = olds;
      if (s.save) msaved[s.tid] = old;
      mflags[s.tid] = nf;
    end
    if (fire && !p && mcnt < (1 << CW) - 1) mcnt++;
    if (s.flush) begin
      mvm = 0; mrm = 0; mmm = 0;
    end else if (!s.stall) begin
      mvm = s.valid; mrm = s.reg_w && cex; mmm = s.mem_w && cex;
    end
    if (!s.stall) mtid = s.tid;
    q.push_back(model_snapshot());
  endtask

  function automatic stim_t ins(input logic [1:0] tid, input logic [3:0] cond,
                                input logic [3:0] alu, input logic [1:0] fw);
    stim_t s;
    s = '0;
    s.valid = 1; s.tid = tid; s.cond = cond; s.alu = alu; s.fw = fw;
    return s;
  endfunction

  // Asynchronous reset applied between edges; outputs must clear before the next edge.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    model_reset();
    compare_regs("reset", model_snapshot());
    @(negedge clk);
    drive('0);
    reset = 1'b1;
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (reset && q.size() > 0) begin
        mon_e = q.pop_front();
        compare_regs("mem", mon_e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    stim_t s;
    drive('0);
    model_reset();
    async_reset();

    go(ins(0, 4'hE, 4'b0100, 2'b11));
    s = ins(0, 4'h0, 4'h0, 2'b00); s.branch = 1; go(s);

    go(ins(1, 4'hE, 4'b1000, 2'b11));
    s = ins(0, 4'h4, 4'h0, 2'b00); s.reg_w = 1; s.mem_w = 1; go(s);
    s = ins(1, 4'h4, 4'h0, 2'b00); s.reg_w = 1; s.pcs = 1; go(s);

    go(ins(0, 4'hE, 4'b1111, 2'b11));
    go(ins(0, 4'hE, 4'b0000, 2'b01));

    s = ins(0, 4'hE, 4'b0011, 2'b11); s.stall = 1; s.reg_w = 1;
    repeat (3) go(s);
    s.flush = 1; go(s);
    s = ins(1, 4'hE, 4'b0000, 2'b11); s.flush = 1; go(s);

    go(ins(0, 4'hE, 4'b0110, 2'b11));
    s = ins(0, 4'hE, 4'h0, 2'b00); s.save = 1; go(s);
    go(ins(0, 4'hE, 4'b1001, 2'b11));
    s = ins(0, 4'hE, 4'b1111, 2'b11); s.restore = 1; go(s);
    go(ins(0, 4'hE, 4'b1010, 2'b11));
    s = ins(0, 4'hF, 4'h0, 2'b00); s.save = 1; s.restore = 1; go(s);
    s = ins(0, 4'hF, 4'h0, 2'b00); s.restore = 1; go(s);

    go(ins(3, 4'hE, 4'b1111, 2'b11));
    s = ins(3, 4'h1, 4'h0, 2'b00); s.reg_w = 1; go(s);
    go(ins(3, 4'h0, 4'h0, 2'b00));

    repeat (20) go(ins(2, 4'hF, 4'h0, 2'b00));

    s = ins(0, 4'hE, 4'b0101, 2'b11); s.stall = 1; s.mem_w = 1; go(s);
    async_reset();

    for (int i = 0; i < 400; i++) begin
      s.valid   = ($urandom_range(0, 9) < 8);
      s.stall   = ($urandom_range(0, 9) < 2);
      s.flush   = ($urandom_range(0, 9) < 1);
      s.tid     = 2'($urandom_range(0, 3));
      s.cond    = 4'($urandom);
      s.alu     = 4'($urandom);
      s.fw      = 2'($urandom);
      s.branch  = 1'($urandom);
      s.pcs     = ($urandom_range(0, 9) < 2);
      s.reg_w   = 1'($urandom);
      s.mem_w   = 1'($urandom);
      s.save    = ($urandom_range(0, 9) < 1);
      s.restore = ($urandom_range(0, 9) < 1);
      go(s);
    end

    @(negedge clk);
    drive('0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      nerr++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
